int_sink_accum: RTL and testbench
=================================

// Module: int_sink_accum
// PURPOSE
//   Downstream consumer stage for a producer that drives a 32-bit `int`
//   result (e.g. a constant-initialised output port).
//   - Accepts values over a valid/ready handshake into a small FIFO.
//   - Drains the FIFO, one entry per cycle, into a signed accumulator.
//   - Reports running sum, sample count and a sticky overflow flag.
//   - Gives the flow a clocked, back-pressured sink for end-to-end
//     sequential lowering tests.
// PARAMETERS
//   WIDTH  32  data and accumulator width in bits, signed two's complement
//   DEPTH  4   FIFO entries; power of two, >= 2
// PORTS
//   clk        in   1               single clock; all state updates on posedge
//   rst        in   1               synchronous reset, active-high
//   in_valid   in   1               upstream data valid
//   in_ready   out  1               sink can accept; combinational = (level != DEPTH)
//   in_data    in   WIDTH           signed value from upstream
//   acc_en     in   1               permit one FIFO pop + accumulate this cycle
//   clear      in   1               synchronous clear of sum/count/overflow
//   sum        out  WIDTH           registered running sum
//   count      out  16              registered number of accumulated samples
//   overflow   out  1               sticky signed-overflow flag
//   level      out  $clog2(DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//   - Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
//   - rst (highest priority), on any posedge with rst=1:
//     - FIFO emptied; level=0.
//     - sum=0, count=0, overflow=0.
//     - in_ready=1 from the first cycle after rst is deasserted.
//   - Push: on in_valid && in_ready, in_data is written at the tail and level increments.
//     - in_valid without in_ready: nothing is written; upstream holds its data.
//   - Pop: on acc_en && level!=0 && !clear, the head is removed and added to sum at the same edge.
//   - Latency: a value accepted at edge N is first poppable in cycle N+1.
//     - It is visible in sum after edge N+1 at the earliest.
//     - There is no empty-FIFO bypass.
//   - Push and pop in the same cycle: level is unchanged and both take effect.
//   - Full FIFO: in_ready=0 even when a pop occurs that cycle (no full bypass).
//   - Ordering: strict FIFO; pointers wrap modulo DEPTH.
//   - Arithmetic: sum_next = sum + head, WIDTH-bit signed.
//     - Overflow condition: both operands have the same sign and the result sign differs.
//     - overflow is set and stays set until clear or rst.
//   - count: increments by 1 per pop and saturates at 16'hFFFF.
//   - clear (priority below rst):
//     - sum=0, count=0, overflow=0.
//     - Inhibits the pop that cycle.
//     - FIFO contents and pushes are unaffected.
//   - Reset mid-operation: pending FIFO entries are discarded and are not accumulated.
// CONFIGURATION
//   INT_SINK_ACC_SAT_EN defined:
//     - On positive overflow, sum clamps to 2^(WIDTH-1)-1.
//     - On negative overflow, sum clamps to -2^(WIDTH-1).
//     - overflow is still set.
//   INT_SINK_ACC_SAT_EN undefined: sum wraps modulo 2^WIDTH; overflow is still set.
// TESTING
//   1. rst 2 cycles; push 42 with acc_en=1 held
//      -> sum=42, count=1 one edge after acceptance; level returns to 0.
//   2. acc_en=0; present 5 values 1..5 back to back
//      -> in_ready=0 after the 4th is accepted, level=4, 5th is held.
//      Then acc_en=1 -> sum=15, count=5.
//   3. Push 32'h7FFFFFFF, then 1, with acc_en=1
//      -> overflow=1; sum=32'h80000000 (macro off) or 32'h7FFFFFFF (macro on).
//   4. Push -7, then 3
//      -> sum=32'hFFFFFFFC (-4), overflow=0.
//   5. level=2 and sum=10; assert clear and acc_en in the same cycle
//      -> sum=0, count=0, level stays 2.
//   6. level=3; assert rst for 1 cycle
//      -> level=0, sum=0, count=0, overflow=0; in_ready=1 the next cycle.

Source files
------------

// File: rtl/int_sink_accum.sv
`default_nettype none
// ============================================================================
// Module   : int_sink_accum
// Brief    : Back-pressured sink for a signed integer stream. Values enter a
//            small FIFO over valid/ready and are drained one per cycle into a
//            signed accumulator that reports sum, sample count and a sticky
//            overflow flag.
// Config   : INT_SINK_ACC_SAT_EN - when defined, the accumulator clamps to
//            the signed limits on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module int_sink_accum #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     acc_en,
  input  logic                     clear,
  output logic [WIDTH-1:0]         sum,
  output logic [15:0]              count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
`ifdef INT_SINK_ACC_SAT_EN
  localparam logic [WIDTH-1:0] SUM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SUM_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [15:0]      count_q,  count_d;
  logic             ovf_q,    ovf_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] raw_sum;
  logic             ovf_det;
  logic [WIDTH-1:0] acc_val;

  // Ready depends only on occupancy: a full FIFO refuses data even if it pops.
  assign in_ready = (level_q != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  // clear wins over a pop so the cleared sum never absorbs a sample.
  assign pop      = acc_en && (level_q != '0) && !clear;
  assign head     = mem_q[rd_ptr_q];

  assign sum      = sum_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign level    = level_q;

  // Signed add of head into the running sum with overflow detection.
  always_comb begin
    raw_sum = sum_q + head;
    ovf_det = (sum_q[WIDTH-1] == head[WIDTH-1]) &&
              (raw_sum[WIDTH-1] != sum_q[WIDTH-1]);
`ifdef INT_SINK_ACC_SAT_EN
    // Operand sign tells which rail was crossed.
    if (ovf_det) begin
      acc_val = sum_q[WIDTH-1] ? SUM_MIN : SUM_MAX;
    end else begin
      acc_val = raw_sum;
    end
`else
    acc_val = raw_sum;
`endif
  end

  // Next-state for FIFO pointers/occupancy and accumulator registers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    sum_d    = sum_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clear) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (pop) begin
      sum_d   = acc_val;
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      ovf_d   = ovf_q | ovf_det;
    end
  end

  // Control and accumulator state; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; entries beyond level are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_sink_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sink_accum
// Brief    : Self-checking bench for int_sink_accum. A table of per-cycle
//            stimulus records with hand-computed expected outputs, followed
//            by hand-written reset sequences. Honours INT_SINK_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sink_accum;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

`ifdef INT_SINK_ACC_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF = 32'h7FFF_FFFF;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              acc_en;
  logic              clear;
  logic [WIDTH-1:0]  sum;
  logic [15:0]       count;
  logic              overflow;
  logic [2:0]        level;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        en;
    logic        clr;
    logic        e_rdy;
    logic [2:0]  e_lvl;
    logic [31:0] e_sum;
    logic [15:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  int_sink_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .acc_en   (acc_en),
    .clear    (clear),
    .sum      (sum),
    .count    (count),
    .overflow (overflow),
    .level    (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [2:0] lvl,
                         input logic [31:0] s, input logic [15:0] c, input logic o);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, ".level"},    {29'd0, level},    {29'd0, lvl});
    chk({tag, ".sum"},      sum,               s);
    chk({tag, ".count"},    {16'd0, count},    {16'd0, c});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, o});
  endtask

  task automatic addv(input logic v, input logic [31:0] d, input logic en, input logic clr,
                      input logic rdy, input logic [2:0] lvl, input logic [31:0] s,
                      input logic [15:0] c, input logic o);
    vec_t t;
    t.v = v; t.d = d; t.en = en; t.clr = clr;
    t.e_rdy = rdy; t.e_lvl = lvl; t.e_sum = s; t.e_cnt = c; t.e_ovf = o;
    vecs.push_back(t);
  endtask

  // Apply inputs for one cycle, then sample just after the edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic en, input logic clr);
    rst = r; in_valid = v; in_data = d; acc_en = en; clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; acc_en = 1'b0; clear = 1'b0;

    //    v  data           en clr  rdy lvl sum           cnt ovf
    // 1: single value with acc_en held
    addv(1, 32'd42,         1, 0,   1, 1, 32'd0,        0, 0);
    addv(0, 32'd0,          1, 0,   1, 0, 32'd42,       1, 0);
    addv(0, 32'd0,          0, 1,   1, 0, 32'd0,        0, 0);
    // 2: fill to full with acc_en low, fifth value held, then drain
    addv(1, 32'd1,          0, 0,   1, 1, 32'd0,        0, 0);
    addv(1, 32'd2,          0, 0,   1, 2, 32'd0,        0, 0);
    addv(1, 32'd3,          0, 0,   1, 3, 32'd0,        0, 0);
    addv(1, 32'd4,          0, 0,   0, 4, 32'd0,        0, 0);
    addv(1, 32'd5,          0, 0,   0, 4, 32'd0,        0, 0);
    addv(1, 32'd5,          1, 0,   1, 3, 32'd1,        1, 0);  // full: pop only
    addv(1, 32'd5,          1, 0,   1, 3, 32'd3,        2, 0);  // push+pop
    addv(0, 32'd0,          1, 0,   1, 2, 32'd6,        3, 0);
    addv(0, 32'd0,          1, 0,   1, 1, 32'd10,       4, 0);
    addv(0, 32'd0,          1, 0,   1, 0, 32'd15,       5, 0);
    addv(0, 32'd0,          1, 0,   1, 0, 32'd15,       5, 0);  // empty: no pop
    addv(0, 32'd0,          0, 1,   1, 0, 32'd0,        0, 0);
    // 3: positive overflow, sticky while idle
    addv(1, 32'h7FFF_FFFF,  1, 0,   1, 1, 32'd0,        0, 0);
    addv(1, 32'd1,          1, 0,   1, 1, 32'h7FFF_FFFF,1, 0);
    addv(0, 32'd0,          1, 0,   1, 0, POS_OVF,      2, 1);
    addv(0, 32'd0,          0, 0,   1, 0, POS_OVF,      2, 1);
    addv(0, 32'd0,          0, 1,   1, 0, 32'd0,        0, 0);
    // 4: mixed signs, no overflow
    addv(1, 32'hFFFF_FFF9,  1, 0,   1, 1, 32'd0,        0, 0);
    addv(1, 32'd3,          1, 0,   1, 1, 32'hFFFF_FFF9,1, 0);
    addv(0, 32'd0,          1, 0,   1, 0, 32'hFFFF_FFFC,2, 0);
    addv(0, 32'd0,          0, 1,   1, 0, 32'd0,        0, 0);
    // negative overflow
    addv(1, 32'h8000_0000,  1, 0,   1, 1, 32'd0,        0, 0);
    addv(1, 32'hFFFF_FFFF,  1, 0,   1, 1, 32'h8000_0000,1, 0);
    addv(0, 32'd0,          1, 0,   1, 0, NEG_OVF,      2, 1);
    addv(0, 32'd0,          0, 1,   1, 0, 32'd0,        0, 0);
    // 5: build level=2, sum=10; clear+acc_en (with a push) keeps the FIFO
    addv(1, 32'd10,         1, 0,   1, 1, 32'd0,        0, 0);
    addv(0, 32'd0,          1, 0,   1, 0, 32'd10,       1, 0);
    addv(1, 32'd100,        0, 0,   1, 1, 32'd10,       1, 0);
    addv(1, 32'd200,        0, 0,   1, 2, 32'd10,       1, 0);
    addv(1, 32'd300,        1, 1,   1, 3, 32'd0,        0, 0);
    addv(0, 32'd0,          1, 0,   1, 2, 32'd100,      1, 0);

    // Reset held for two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk_all("reset", 1'b1, 3'd0, 32'd0, 16'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(0, vecs[i].v, vecs[i].d, vecs[i].en, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_lvl,
              vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_ovf);
    end

    // 6: level=3 (200, 300, 7), then a one-cycle reset mid-operation
    cycle(0, 1, 32'd7, 0, 0);
    chk_all("pre_rst", 1'b1, 3'd3, 32'd100, 16'd1, 1'b0);
    cycle(1, 0, 32'd0, 1, 0);
    chk_all("mid_rst", 1'b1, 3'd0, 32'd0, 16'd0, 1'b0);
    // Discarded entries must not be accumulated
    cycle(0, 0, 32'd0, 1, 0);
    chk_all("post_rst_idle", 1'b1, 3'd0, 32'd0, 16'd0, 1'b0);
    cycle(0, 1, 32'd9, 1, 0);
    chk_all("post_rst_push", 1'b1, 3'd1, 32'd0, 16'd0, 1'b0);
    cycle(0, 0, 32'd0, 1, 0);
    chk_all("post_rst_pop", 1'b1, 3'd0, 32'd9, 16'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
